// File: rtl/uart_periph_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit
// positions and the 2-bit state encoding used by both the TX and RX engines.
package uart_periph_pkg;

    localparam logic [31:0] OFF_TXD = 32'h0;
    localparam logic [31:0] OFF_RXD = 32'h4;
    localparam logic [31:0] OFF_CON = 32'h8;

    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_FERR     = 5;
    localparam int CON_OVR      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter: load_i restarts it for a full or half bit,
// tick_o pulses for one cycle each time the loaded interval expires while enabled.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 5208,
    parameter int CW       = $clog2(BAUD_DIV)
) (
    input  logic clk,
    input  logic reset_b,
    input  logic en_i,
    input  logic load_i,
    input  logic half_i,
    output logic tick_o
);

    localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = half_i ? HALF_LD : FULL_LD;
        end else if (en_i) begin
            // Auto-reload so consecutive bits need no explicit load.
            cnt_d = (cnt_q == '0) ? FULL_LD : cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= FULL_LD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART on the data-memory peripheral bus: TXD/RXD/CON registers,
// combinational read data, side-effect clears on reads, registered level interrupt.
module uart_periph
    import uart_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h40000018,
    parameter int          BAUD_DIV  = 5208
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    localparam logic [31:0] TXD_ADDR = BASE_ADDR + OFF_TXD;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + OFF_RXD;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + OFF_CON;

    logic hit_txd, hit_rxd, hit_con;
    logic txd_wr, con_wr, rxd_rd, con_rd;
    logic unused_bits;

    assign hit_txd = (addr[31:2] == TXD_ADDR[31:2]);
    assign hit_rxd = (addr[31:2] == RXD_ADDR[31:2]);
    assign hit_con = (addr[31:2] == CON_ADDR[31:2]);
    assign sel     = hit_txd | hit_rxd | hit_con;
    assign txd_wr  = wr & hit_txd;
    assign con_wr  = wr & hit_con;
    assign rxd_rd  = rd & hit_rxd;
    assign con_rd  = rd & hit_con;
    assign unused_bits = ^{wdata[31:8], addr[1:0]};

    // ---------------- TX engine ----------------
    uart_state_e tx_st_q, tx_st_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_q, tx_d;
    logic        tx_tick, tx_load, tx_accept, tx_done_set, tx_busy;

    assign tx_busy = (tx_st_q != ST_IDLE);

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_tx_baud (
        .clk     (clk),
        .reset_b (reset_b),
        .en_i    (tx_busy),
        .load_i  (tx_load),
        .half_i  (1'b0),
        .tick_o  (tx_tick)
    );

    always_comb begin
        tx_st_d     = tx_st_q;
        tx_sh_d     = tx_sh_q;
        tx_bit_d    = tx_bit_q;
        tx_d        = tx_q;
        tx_load     = 1'b0;
        tx_accept   = 1'b0;
        tx_done_set = 1'b0;
        case (tx_st_q)
            ST_IDLE: tx_accept = txd_wr;
            ST_START: if (tx_tick) begin
                tx_d     = tx_sh_q[0];
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = 3'd0;
                tx_st_d  = ST_DATA;
            end
            ST_DATA: if (tx_tick) begin
                if (tx_bit_q == 3'd7) begin
                    tx_d    = 1'b1;
                    tx_st_d = ST_STOP;
                end else begin
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 3'd1;
                end
            end
            ST_STOP: if (tx_tick) begin
                tx_st_d     = ST_IDLE;
                tx_done_set = 1'b1;
                tx_accept   = txd_wr;
            end
            default: tx_st_d = ST_IDLE;
        endcase
        // Back-to-back frames: a write on the last stop-bit cycle starts the next one.
        if (tx_accept) begin
            tx_sh_d = wdata[7:0];
            tx_d    = 1'b0;
            tx_load = 1'b1;
            tx_st_d = ST_START;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_st_q  <= ST_IDLE;
            tx_sh_q  <= '0;
            tx_bit_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_sh_q  <= tx_sh_d;
            tx_bit_q <= tx_bit_d;
            tx_q     <= tx_d;
        end
    end

    assign uart_tx = tx_q;

    // ---------------- RX engine ----------------
    uart_state_e rx_st_q, rx_st_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        rx_fall, rx_tick, rx_load, rx_half, rx_set, ferr_set;

    assign rx_fall = rx_s3_q & ~rx_s2_q;

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_rx_baud (
        .clk     (clk),
        .reset_b (reset_b),
        .en_i    (rx_st_q != ST_IDLE),
        .load_i  (rx_load),
        .half_i  (rx_half),
        .tick_o  (rx_tick)
    );

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_sh_d  = rx_sh_q;
        rx_bit_d = rx_bit_q;
        rx_load  = 1'b0;
        rx_half  = 1'b0;
        rx_set   = 1'b0;
        ferr_set = 1'b0;
        case (rx_st_q)
            ST_IDLE: if (rx_fall) begin
                rx_load = 1'b1;
                rx_half = 1'b1;
                rx_st_d = ST_START;
            end
            ST_START: if (rx_tick) begin
                rx_bit_d = 3'd0;
                rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_tick) begin
                rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) begin
                    rx_st_d = ST_STOP;
                end else begin
                    rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            ST_STOP: if (rx_tick) begin
                rx_st_d  = ST_IDLE;
                rx_set   = rx_s2_q;
                ferr_set = ~rx_s2_q;
            end
            default: rx_st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_st_q  <= ST_IDLE;
            rx_sh_q  <= '0;
            rx_bit_q <= '0;
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rx_s3_q  <= 1'b1;
        end else begin
            rx_st_q  <= rx_st_d;
            rx_sh_q  <= rx_sh_d;
            rx_bit_q <= rx_bit_d;
            rx_s1_q  <= uart_rx;
            rx_s2_q  <= rx_s1_q;
            rx_s3_q  <= rx_s2_q;
        end
    end

    // ---------------- Registers and flags ----------------
    logic [7:0] rx_byte_q, rx_byte_d;
    logic tx_ie_q, tx_ie_d, rx_ie_q, rx_ie_d;
    logic tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
    logic ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;

    // Hardware sets take priority over read-side-effect clears on the same edge.
    always_comb begin
        tx_ie_d    = con_wr ? wdata[CON_TX_IE] : tx_ie_q;
        rx_ie_d    = con_wr ? wdata[CON_RX_IE] : rx_ie_q;
        rx_byte_d  = rx_set ? rx_sh_q : rx_byte_q;
        rx_valid_d = rx_set ? 1'b1 : (rxd_rd ? 1'b0 : rx_valid_q);
        ovr_d      = (rx_set & rx_valid_q) ? 1'b1 : (rxd_rd ? 1'b0 : ovr_q);
        ferr_d     = ferr_set ? 1'b1 : (con_rd ? 1'b0 : ferr_q);
        tx_done_d  = tx_done_set ? 1'b1 : (con_rd ? 1'b0 : tx_done_q);
        irq_d      = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_valid_q);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_ie_q    <= 1'b0;
            rx_ie_q    <= 1'b0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            tx_done_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_ie_q    <= tx_ie_d;
            rx_ie_q    <= rx_ie_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            tx_done_q  <= tx_done_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        rdata = '0;
        if (rxd_rd) begin
            rdata = {24'b0, rx_byte_q};
        end else if (con_rd) begin
            rdata = {25'b0, ovr_q, ferr_q, tx_busy, rx_valid_q, tx_done_q, rx_ie_q, tx_ie_q};
        end
    end

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph with BAUD_DIV=4: register decode table followed by
// TX framing, RX reception, overrun, glitch, framing error and mid-frame reset sequences.
module tb_uart_periph;

    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'h4;
    localparam logic [31:0] CON  = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        sel;
    logic        uart_rx = 1'b1;
    logic        uart_tx, irq;

    int n_cmp = 0;
    int n_err = 0;

    uart_periph #(.BASE_ADDR(BASE), .BAUD_DIV(4)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .sel     (sel),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_sel;
        logic        exp_irq;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus(1'b1, 1'b0, a, 32'h0);
        @(negedge clk);
        chk(name, rdata, exp);
        step();
        idle();
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
        step();
        idle();
    endtask

    // Checks every bit cycle of one frame plus four idle cycles afterwards.
    task automatic run_tx(input logic [7:0] b, input bit inject);
        logic expb;
        wr_reg(TXD, {24'h0, b});
        for (int c = 0; c < 44; c++) begin
            idle();
            if (inject && c == 5) bus(1'b0, 1'b1, TXD, 32'hA5);
            if (inject && (c == 9 || c == 39)) bus(1'b1, 1'b0, CON, 32'h0);
            @(negedge clk);
            if (c < 4)        expb = 1'b0;
            else if (c >= 36) expb = 1'b1;
            else              expb = b[c/4 - 1];
            chk($sformatf("tx_bit_c%0d", c), {31'h0, uart_tx}, {31'h0, expb});
            if (inject && c == 9)  chk("con_busy_mid", rdata, 32'h10);
            if (inject && c == 39) chk("con_busy_last", rdata, 32'h10);
            step();
        end
        idle();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      uart_rx = 1'b0;
            else if (k == 9) uart_rx = stopb;
            else             uart_rx = b[k-1];
            repeat (4) step();
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        bit found;
        vt[0]  = '{1'b1, 1'b0, CON,          32'h0,        32'h0,  1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, TXD,          32'h0,        32'h0,  1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, RXD,          32'h0,        32'h0,  1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, CON,          32'hFFFFFFFF, 32'h0,  1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, CON,          32'h0,        32'h03, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b0, BASE + 32'hC, 32'h0,        32'h0,  1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, BASE - 32'h4, 32'h0,        32'h0,  1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, BASE + 32'hB, 32'h0,        32'h03, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b1, BASE + 32'hC, 32'h0,        32'h0,  1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, CON,          32'h0,        32'h03, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, CON,          32'h0,        32'h0,  1'b1, 1'b0};
        vt[11] = '{1'b1, 1'b0, CON,          32'h0,        32'h0,  1'b1, 1'b0};
        vt[12] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h0,  1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset_b = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            bus(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
            chk($sformatf("vec%0d_sel", i), {31'h0, sel}, {31'h0, vt[i].exp_sel});
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vt[i].exp_irq});
            step();
        end
        idle();

        // TX 0x5A with a dropped mid-frame write and a CON read on the completion edge.
        run_tx(8'h5A, 1'b1);
        rd_chk("con_tx_done", CON, 32'h04);
        rd_chk("con_tx_done_clr", CON, 32'h00);

        // RX 0xC3 with rx interrupt enabled.
        wr_reg(CON, 32'h02);
        send_frame(8'hC3, 1'b1);
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            bus(1'b1, 1'b0, CON, 32'h0);
            @(negedge clk);
            if (rdata[3]) begin
                found = 1'b1;
                chk("rx_con_valid", rdata, 32'h0A);
                chk("rx_irq_lag", {31'h0, irq}, 32'h0);
            end
            step();
        end
        chk("rx_valid_wait", {31'h0, found}, 32'h1);
        idle();
        @(negedge clk);
        chk("rx_irq_set", {31'h0, irq}, 32'h1);
        step();
        rd_chk("rxd_c3", RXD, 32'hC3);
        rd_chk("rx_con_cleared", CON, 32'h02);
        @(negedge clk);
        chk("rx_irq_drop", {31'h0, irq}, 32'h0);
        step();

        // Overrun.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) step();
        rd_chk("ovr_con", CON, 32'h4A);
        rd_chk("ovr_rxd", RXD, 32'h22);
        rd_chk("ovr_con_clr", CON, 32'h02);

        // One-cycle glitch is a false start.
        uart_rx = 1'b0;
        step();
        uart_rx = 1'b1;
        repeat (12) step();
        rd_chk("glitch_con", CON, 32'h02);
        rd_chk("glitch_rxd", RXD, 32'h22);

        // Framing error.
        send_frame(8'h5A, 1'b0);
        repeat (4) step();
        rd_chk("ferr_con", CON, 32'h22);
        rd_chk("ferr_rxd", RXD, 32'h22);
        rd_chk("ferr_con_clr", CON, 32'h02);

        // Mid-frame reset with irq pending.
        send_frame(8'h77, 1'b1);
        repeat (3) step();
        chk("pre_reset_irq", {31'h0, irq}, 32'h1);
        wr_reg(TXD, 32'h3C);
        repeat (10) step();
        chk("pre_reset_tx", {31'h0, uart_tx}, 32'h0);
        #2;
        reset_b = 1'b0;
        bus(1'b1, 1'b0, CON, 32'h0);
        #1;
        chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_con", rdata, 32'h0);
        addr = RXD;
        #1;
        chk("rst_rxd", rdata, 32'h0);
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        idle();
        step();
        rd_chk("post_rst_con", CON, 32'h0);
        run_tx(8'h96, 1'b0);
        rd_chk("post_rst_done", CON, 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
Memory-mapped UART responder on the data-memory peripheral bus. It answers the MEM stage's rd/wr/addr/wdata accesses, in parallel with data RAM and the other peripherals. It serialises bytes written by the CPU onto uart_tx and deserialises uart_rx into a readable register. It raises a level interrupt toward the CPU exception logic.

Parameters:
BASE_ADDR, 32'h40000018, byte address of TXD; RXD is at BASE+4, CON at BASE+8.
BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600); must be at least 4.

Ports:
clk  in  1  system clock
reset_b  in  1  asynchronous active-low reset
rd  in  1  read strobe from MEM stage
wr  in  1  write strobe from MEM stage
addr  in  32  byte address (ALU result)
wdata  in  32  write data
rdata  out  32  read data; combinational, 0 when not selected
sel  out  1  combinational; addr hits one of the three registers (addr[1:0] ignored)
uart_rx  in  1  serial input, asynchronous to clk
uart_tx  out  1  serial output, idle high
irq  out  1  level interrupt request

Behaviour:
- Reset (asynchronous on reset_b low, effective immediately): uart_tx=1; irq=0; both FSMs return to IDLE; all CON bits=0; RXD=0. Any in-flight frame is aborted.
- Read path: rdata is combinational from addr and rd within the same cycle. TXD reads return 0. RXD reads return {24'b0, rx_byte}. CON reads return {25'b0, ovr, ferr, tx_busy, rx_valid, tx_done, rx_ie, tx_ie} as bits [6:0].
- Read side effects take effect at the clk edge while rd is high and the address matches:
  - An RXD read clears rx_valid and ovr.
  - A CON read clears tx_done and ferr.
- CON writes update only tx_ie and rx_ie (wdata[1:0]). All other bits are read-only.
- TXD write while tx_busy=0: latch wdata[7:0] and set tx_busy the same edge. The start bit begins on the next cycle.
- TXD write while tx_busy=1: ignored; no status change.
- TX FSM states are IDLE, START, DATA, STOP.
  - Each bit is held for exactly BAUD_DIV cycles. Data is sent LSB first. Format is 8N1.
  - At the end of STOP: tx_busy=0 and tx_done=1. A new byte may be accepted on that same edge.
- RX input: uart_rx passes through a 2-FF synchroniser plus an edge-detect flop.
- RX FSM states are IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised falling edge.
  - START: re-sample after BAUD_DIV/2 cycles. If the line is high it is a false start; return to IDLE.
  - DATA: sample every BAUD_DIV cycles at bit centres.
  - STOP, sampled high: load RXD and set rx_valid. If rx_valid was already 1, also set ovr; the new byte overwrites.
  - STOP, sampled low: set ferr, discard the byte, leave RXD unchanged, and return to IDLE.
- Simultaneous events: when a hardware set and a software clear hit the same flag on the same edge, the set wins. Examples are an RXD read coinciding with byte completion, and a CON read coinciding with tx_done.
- irq = (tx_ie & tx_done) | (rx_ie & rx_valid), registered (one cycle after the flag changes).
- Accesses to unmapped addresses: sel=0, rdata=0, no side effects. rd and wr both high on the same address: the write applies and the read side effect also applies.

Decomposition:
- Shared peripheral package:
  - register offsets (TXD=0, RXD=4, CON=8);
  - CON bit-index constants;
  - the FSM state encodings (2-bit, shared by TX and RX).
- Natural sub-module: uart_baud_cnt, a loadable down-counter producing full-bit and half-bit ticks. Instantiate it twice, once for TX and once for RX.
- The register decode and flags stay in uart_periph.

Test Plan:
- BAUD_DIV=4. Write TXD=0x5A, then poll CON.
  - uart_tx shows 0,0,1,0,1,1,0,1,0,1, each bit held 4 cycles.
  - tx_busy=1 during the frame; tx_done=1 afterwards.
  - A CON read returns 0x04 and then reads 0x00.
- Write TXD=0xA5 mid-frame of 0x5A: the second write is dropped, uart_tx carries only 0x5A, and no extra frame follows.
- Drive uart_rx with frame 0xC3 (8N1, 4 cycles/bit) and CON=0x02:
  - rx_valid=1 and irq=1 one cycle later;
  - RXD read returns 0xC3;
  - rx_valid=0 and irq drops.
- Send two frames 0x11 then 0x22 without reading: RXD=0x22, ovr=1. An RXD read clears both rx_valid and ovr.
- Two stimuli on uart_rx:
  - A 1-cycle low glitch: no frame, flags unchanged.
  - A frame with stop bit 0: ferr=1, rx_valid unchanged, RXD unchanged.
- Assert reset_b low mid-TX frame: uart_tx=1 immediately, tx_busy=0, irq=0, CON reads 0. A TXD write after release transmits normally.
